// File: rtl/tdm_mux8_pkg.sv
// tdm_mux8_pkg: shared constants, FSM state type and the channel-to-select map
// for the 8-channel TDM transmit link and its demux-side receiver.
package tdm_mux8_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    // The demux routes a bit to lane 4*s[2] + 2*s[0] + s[1], so the two low
    // channel bits are swapped on the way out.
    function automatic logic [SEL_W-1:0] chan_to_sel(input logic [SEL_W-1:0] cnt);
        return {cnt[2], cnt[0], cnt[1]};
    endfunction

endpackage

// File: rtl/tdm_sel_enc.sv
// tdm_sel_enc: combinational channel index to demux select encoder.
//   chan : channel index 0..7
//   sel  : demux select for that channel
module tdm_sel_enc
    import tdm_mux8_pkg::*;
(
    input  logic [SEL_W-1:0] chan,
    output logic [SEL_W-1:0] sel
);

    always_comb sel = chan_to_sel(chan);

endmodule

// File: rtl/tdm_mux8_tx.sv
// tdm_mux8_tx: accepts one 8-bit word per frame over valid/ready and sends it
// one channel per clock as a data bit plus demux select.
//   clk, rst         : clock, asynchronous active-high reset
//   flush            : synchronous abort of the current frame
//   par_data/valid   : producer word and its valid
//   par_ready        : word can be accepted this cycle
//   in, s            : serial bit and demux select of the current beat
//   ser_valid        : in/s carry a beat
//   frame_last       : current beat is channel 7
//   busy             : frame in progress
module tdm_mux8_tx
    import tdm_mux8_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [N_CH-1:0]  par_data,
    input  logic             par_valid,
    output logic             par_ready,
    output logic             in,
    output logic [SEL_W-1:0] s,
    output logic             ser_valid,
    output logic             frame_last,
    output logic             busy
);

    state_t            state;
    logic [SEL_W-1:0]  cnt;
    logic [N_CH-1:0]   shreg;
    logic [SEL_W-1:0]  cnt_nx;
    logic [SEL_W-1:0]  sel_nx;
    logic              accept;

    // Ready in IDLE and on the last beat so frames can run back to back;
    // flush blocks acceptance in the cycle it is asserted.
    always_comb par_ready = !rst && !flush && (state == IDLE || frame_last);
    always_comb accept    = par_valid && par_ready;
    always_comb cnt_nx    = accept ? '0 : cnt + 3'd1;

    tdm_sel_enc u_sel_enc (
        .chan (cnt_nx),
        .sel  (sel_nx)
    );

    // Outputs are registered: each branch loads the beat for cnt_nx so the
    // registered outputs always describe the channel held in cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            in         <= 1'b0;
            s          <= '0;
            ser_valid  <= 1'b0;
            frame_last <= 1'b0;
            busy       <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            cnt        <= '0;
            ser_valid  <= 1'b0;
            frame_last <= 1'b0;
            busy       <= 1'b0;
        end else if (accept) begin
            state      <= SEND;
            cnt        <= cnt_nx;
            shreg      <= par_data;
            in         <= par_data[0];
            s          <= sel_nx;
            ser_valid  <= 1'b1;
            frame_last <= 1'b0;
            busy       <= 1'b1;
        end else if (state == SEND && cnt != 3'd7) begin
            cnt        <= cnt_nx;
            in         <= shreg[cnt_nx];
            s          <= sel_nx;
            frame_last <= (cnt_nx == 3'd7);
        end else if (state == SEND) begin
            state      <= IDLE;
            ser_valid  <= 1'b0;
            frame_last <= 1'b0;
            busy       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tdm_mux8_tx.sv
// tb_tdm_mux8_tx: randomized and directed bench against a queue-of-beats model.
module tb_tdm_mux8_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] par_data;
    logic       par_valid;
    logic       par_ready;
    logic       in;
    logic [2:0] s;
    logic       ser_valid;
    logic       frame_last;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic b;
        int   ch;
    } beat_t;

    beat_t      q[$];
    logic       last_in;
    logic [2:0] last_s;
    logic [7:0] dmx;

    always #5 clk = ~clk;

    tdm_mux8_tx dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .par_data   (par_data),
        .par_valid  (par_valid),
        .par_ready  (par_ready),
        .in         (in),
        .s          (s),
        .ser_valid  (ser_valid),
        .frame_last (frame_last),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Select that makes the demux route to lane ch (found by search over the lane rule).
    function automatic logic [2:0] sel_of(input int ch);
        logic [2:0] t;
        sel_of = '0;
        for (int i = 0; i < 8; i++) begin
            t = i[2:0];
            if (4 * t[2] + 2 * t[0] + t[1] == ch) sel_of = t;
        end
    endfunction

    function automatic int lane_of(input logic [2:0] sel);
        return 4 * sel[2] + 2 * sel[0] + sel[1];
    endfunction

    task automatic model_reset();
        q.delete();
        last_in = 1'b0;
        last_s  = '0;
    endtask

    // One cycle: drive, check against the model before the edge, then advance the model.
    task automatic step(input logic v, input logic [7:0] d, input logic f);
        logic exp_ready;
        @(negedge clk);
        par_valid = v;
        par_data  = d;
        flush     = f;
        #1;
        exp_ready = !f && q.size() <= 1;
        chk("par_ready", par_ready, exp_ready);
        chk("ser_valid", ser_valid, q.size() != 0);
        chk("busy", busy, q.size() != 0);
        chk("frame_last", frame_last, q.size() != 0 && q[0].ch == 7);
        chk("in", in, q.size() != 0 ? q[0].b : last_in);
        chk("s", s, q.size() != 0 ? sel_of(q[0].ch) : last_s);
        if (ser_valid) dmx[lane_of(s)] = in;
        @(posedge clk);
        if (f) q.delete();
        else begin
            if (q.size() != 0) void'(q.pop_front());
            if (v && exp_ready)
                for (int c = 0; c < 8; c++) q.push_back('{d[c], c});
        end
        if (q.size() != 0) begin
            last_in = q[0].b;
            last_s  = sel_of(q[0].ch);
        end
    endtask

    initial begin
        logic [7:0] w;
        rst       = 1'b1;
        flush     = 1'b0;
        par_valid = 1'b0;
        par_data  = '0;
        dmx       = '0;
        model_reset();
        #1;
        chk("rst_in", in, 0);
        chk("rst_s", s, 0);
        chk("rst_ser_valid", ser_valid, 0);
        chk("rst_frame_last", frame_last, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // single frame
        step(1, 8'hA5, 0);
        repeat (10) step(0, 8'h00, 0);

        // back to back, second word held valid through the first frame
        step(1, 8'hFF, 0);
        repeat (8) step(1, 8'h00, 0);
        repeat (10) step(0, 8'h00, 0);

        // loopback through a demux model with walking ones
        for (int k = 0; k < 8; k++) begin
            w = 8'h01 << k;
            step(1, w, 0);
            repeat (9) step(0, 8'h00, 0);
            chk("loopback", dmx, w);
        end

        // flush on the fourth beat, then a full frame
        step(1, 8'h3C, 0);
        repeat (3) step(0, 8'h00, 0);
        step(1, 8'h55, 1);
        step(0, 8'h00, 0);
        step(1, 8'hC3, 0);
        repeat (10) step(0, 8'h00, 0);

        // asynchronous reset between edges in the middle of a frame
        step(1, 8'h96, 0);
        repeat (5) step(0, 8'h00, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_in", in, 0);
        chk("arst_s", s, 0);
        chk("arst_ser_valid", ser_valid, 0);
        chk("arst_frame_last", frame_last, 0);
        chk("arst_busy", busy, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) step(0, 8'h00, 0);

        // par_data toggling with par_valid held
        step(1, 8'h6B, 0);
        repeat (12) step(1, 8'($urandom), 0);
        repeat (10) step(0, 8'($urandom), 0);

        // random traffic with occasional flush
        repeat (400) step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0);
        repeat (10) step(0, 8'h00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
